// File: rtl/sc1602_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : sc1602_bus_responder
// Brief    : Responder-side model of an SC1602 / HD44780 parallel LCD bus.
//            Synchronizes the bus pins, decodes 4-bit and 8-bit accesses and
//            maintains DDRAM, the address counter and the display flags.
// Revision : 1.0  initial release
// ============================================================================
module sc1602_bus_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_db_i,
  output logic [3:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [6:0] addr_o,
  output logic [5:0] shift_o,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       four_bit,
  output logic       two_line,
  output logic       busy,
  output logic       protocol_err
);

  localparam int c_max_cycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_busy_load  = c_cnt_w'(BUSY_CYCLES);
  localparam logic [c_cnt_w-1:0] c_clear_load = c_cnt_w'(CLEAR_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

  // Pin pipeline: {EN, RS, RW, DB[3:0]}
  logic [6:0] r_pin_s1, r_pin_s2, r_pin_s3;

  logic [3:0] r_db_o;
  logic       r_oe;
  logic       r_wr_valid;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [6:0] r_ac;
  logic [5:0] r_shift;
  logic       r_disp, r_cur, r_blink;
  logic       r_four_bit, r_two_line;
  logic       r_perr;
  logic       r_id, r_s;
  logic       r_cgram_sel;
  logic       r_phase_lo;
  logic [3:0] r_hi_nib;
  logic       r_hi_rs, r_hi_rw;
  logic [c_cnt_w-1:0] r_busy_cnt;
  fill_state_t r_state;
  logic [6:0] r_fill_idx;
  logic [7:0] r_ddram [0:127];
  logic [7:0] r_rd_data;

  logic       w_en2, w_rs2, w_rw2, w_en3, w_rs3, w_rw3;
  logic [3:0] w_db3;
  logic       w_rise, w_fall, w_busy;
  logic       w_acc_done, w_pair_err;
  logic [7:0] w_byte;
  logic       w_wr, w_drop, w_exec, w_exec_data, w_exec_inst, w_long;
  logic [3:0] w_rd_nib;
  logic       w_mem_we;
  logic [6:0] w_mem_addr;
  logic [7:0] w_mem_data;

  assign w_en2  = r_pin_s2[6];
  assign w_rs2  = r_pin_s2[5];
  assign w_rw2  = r_pin_s2[4];
  assign w_en3  = r_pin_s3[6];
  assign w_rs3  = r_pin_s3[5];
  assign w_rw3  = r_pin_s3[4];
  assign w_db3  = r_pin_s3[3:0];
  assign w_rise = w_en2 & ~w_en3;
  assign w_fall = ~w_en2 & w_en3;
  assign w_busy = (r_busy_cnt != '0);

  // Address-counter step with the one-line / two-line wrap points
  function automatic logic [6:0] f_ac_step(input logic [6:0] ac, input logic up, input logic two);
    logic [6:0] nxt;
    nxt = up ? ac + 7'd1 : ac - 7'd1;
    if (two) begin
      if (up && ac == 7'h27)       nxt = 7'h40;
      else if (up && ac == 7'h67)  nxt = 7'h00;
      else if (!up && ac == 7'h40) nxt = 7'h27;
      else if (!up && ac == 7'h00) nxt = 7'h67;
    end else begin
      if (up && ac >= 7'h4F)       nxt = 7'h00;
      else if (!up && ac == 7'h00) nxt = 7'h4F;
    end
    return nxt;
  endfunction

  // Display shift offset step, modulo 40
  function automatic logic [5:0] f_shift_step(input logic [5:0] sh, input logic up);
    if (up) return (sh >= 6'd39) ? 6'd0 : sh + 6'd1;
    else    return (sh == 6'd0) ? 6'd39 : sh - 6'd1;
  endfunction

  // Pin synchronizers plus the edge-detect stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pin_s1 <= '0;
      r_pin_s2 <= '0;
      r_pin_s3 <= '0;
    end else begin
      r_pin_s1 <= {lcd_en, lcd_rs, lcd_rw, lcd_db_i};
      r_pin_s2 <= r_pin_s1;
      r_pin_s3 <= r_pin_s2;
    end
  end

  // Assemble a completed byte access from one 8-bit or two 4-bit transfers
  always_comb begin
    w_acc_done = 1'b0;
    w_pair_err = 1'b0;
    w_byte     = {w_db3, 4'h0};
    if (w_fall) begin
      if (!r_four_bit) begin
        w_acc_done = 1'b1;
      end else if (r_phase_lo) begin
        if (r_hi_rs != w_rs3 || r_hi_rw != w_rw3) begin
          w_pair_err = 1'b1;
        end else begin
          w_acc_done = 1'b1;
          w_byte     = {r_hi_nib, w_db3};
        end
      end
    end
  end

  assign w_wr        = w_acc_done & ~w_rw3;
  assign w_drop      = w_wr & w_busy;
  assign w_exec      = w_wr & ~w_busy;
  assign w_exec_data = w_exec & w_rs3;
  assign w_exec_inst = w_exec & ~w_rs3;
  assign w_long      = ~|w_byte[7:2] & |w_byte[1:0];
  assign w_rd_nib    = w_rs2 ? 4'h0 :
                       (r_four_bit && r_phase_lo) ? r_ac[3:0] : {w_busy, r_ac[6:4]};

  // DDRAM write-port arbitration: the clear fill owns the port while active
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_ac;
    w_mem_data = w_byte;
    if (r_state == S_FILL) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_fill_idx;
      w_mem_data = 8'h20;
    end else if (w_exec_data && !r_cgram_sel) begin
      w_mem_we = 1'b1;
    end
  end

  // DDRAM storage with a registered renderer read port (not reset)
  always_ff @(posedge clk) begin
    if (w_mem_we) r_ddram[w_mem_addr] <= w_mem_data;
    r_rd_data <= r_ddram[rd_addr];
  end

  // Controller state: nibble pairing, decode, busy timer, clear fill, reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_o      <= 4'h0;
      r_oe        <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 7'h00;
      r_wr_data   <= 8'h00;
      r_ac        <= 7'h00;
      r_shift     <= 6'd0;
      r_disp      <= 1'b0;
      r_cur       <= 1'b0;
      r_blink     <= 1'b0;
      r_four_bit  <= 1'b0;
      r_two_line  <= 1'b0;
      r_perr      <= 1'b0;
      r_id        <= 1'b1;
      r_s         <= 1'b0;
      r_cgram_sel <= 1'b0;
      r_phase_lo  <= 1'b0;
      r_hi_nib    <= 4'h0;
      r_hi_rs     <= 1'b0;
      r_hi_rw     <= 1'b0;
      r_busy_cnt  <= '0;
      r_state     <= S_IDLE;
      r_fill_idx  <= 7'h00;
    end else begin
      r_wr_valid <= 1'b0;
      r_perr     <= w_pair_err | w_drop;
      r_oe       <= w_en2 & w_rw2;

      if (w_rise && w_rw2) r_db_o <= w_rd_nib;

      if (w_fall && r_four_bit) begin
        r_phase_lo <= ~r_phase_lo;
        if (!r_phase_lo) begin
          r_hi_nib <= w_db3;
          r_hi_rs  <= w_rs3;
          r_hi_rw  <= w_rw3;
        end
      end

      if (w_busy) r_busy_cnt <= r_busy_cnt - c_cnt_one;
      if (w_exec) r_busy_cnt <= (w_exec_inst && w_long) ? c_clear_load : c_busy_load;

      case (r_state)
        S_FILL: begin
          r_fill_idx <= r_fill_idx + 7'd1;
          if (r_fill_idx == 7'h7F) r_state <= S_IDLE;
        end
        default: ;
      endcase

      if (w_exec_data && !r_cgram_sel) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_ac;
        r_wr_data  <= w_byte;
        r_ac       <= f_ac_step(r_ac, r_id, r_two_line);
        if (r_s) r_shift <= f_shift_step(r_shift, r_id);
      end

      if (w_exec_inst) begin
        if (w_byte[7]) begin
          r_ac        <= w_byte[6:0];
          r_cgram_sel <= 1'b0;
        end else if (w_byte[6]) begin
          r_cgram_sel <= 1'b1;
        end else if (w_byte[5]) begin
          r_four_bit <= ~w_byte[4];
          r_two_line <= w_byte[3];
          if (!w_byte[4]) r_phase_lo <= 1'b0;
        end else if (w_byte[4]) begin
          if (w_byte[3]) r_shift <= f_shift_step(r_shift, ~w_byte[2]);
          else           r_ac    <= f_ac_step(r_ac, w_byte[2], r_two_line);
        end else if (w_byte[3]) begin
          r_disp  <= w_byte[2];
          r_cur   <= w_byte[1];
          r_blink <= w_byte[0];
        end else if (w_byte[2]) begin
          r_id <= w_byte[1];
          r_s  <= w_byte[0];
        end else if (w_byte[1]) begin
          r_ac    <= 7'h00;
          r_shift <= 6'd0;
        end else if (w_byte[0]) begin
          r_ac       <= 7'h00;
          r_shift    <= 6'd0;
          r_id       <= 1'b1;
          r_state    <= S_FILL;
          r_fill_idx <= 7'h00;
        end
      end
    end
  end

  assign lcd_db_o     = r_db_o;
  assign lcd_db_oe    = r_oe;
  assign rd_data      = r_rd_data;
  assign wr_valid     = r_wr_valid;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign addr_o       = r_ac;
  assign shift_o      = r_shift;
  assign display_on   = r_disp;
  assign cursor_on    = r_cur;
  assign blink_on     = r_blink;
  assign four_bit     = r_four_bit;
  assign two_line     = r_two_line;
  assign busy         = w_busy;
  assign protocol_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_sc1602_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc1602_bus_responder
// Brief    : Self-checking bench for sc1602_bus_responder with a behavioural
//            model of the LCD controller state and DDRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_sc1602_bus_responder;

  localparam int BUSY_CYCLES  = 40;
  localparam int CLEAR_CYCLES = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [3:0] lcd_db_i = 4'h0;
  logic [6:0] rd_addr = 7'h00;
  logic [3:0] lcd_db_o;
  logic       lcd_db_oe;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] addr_o;
  logic [5:0] shift_o;
  logic       display_on, cursor_on, blink_on, four_bit, two_line, busy, protocol_err;

  sc1602_bus_responder #(
    .BUSY_CYCLES (BUSY_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_db_i    (lcd_db_i),
    .lcd_db_o    (lcd_db_o),
    .lcd_db_oe   (lcd_db_oe),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .addr_o      (addr_o),
    .shift_o     (shift_o),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .four_bit    (four_bit),
    .two_line    (two_line),
    .busy        (busy),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_ram [128];
  logic [6:0]  m_ac;
  logic [5:0]  m_shift;
  logic        m_id, m_s, m_n, m_four, m_d, m_c, m_b, m_cg;
  logic [14:0] exp_q[$];
  logic [14:0] act_q[$];
  int          perr_cnt = 0;
  int          exp_perr = 0;
  int          busy_run = 0;
  int          last_busy_len = 0;

  // Observe write strobes, error pulses and busy run lengths
  always @(negedge clk) begin
    if (wr_valid) act_q.push_back({wr_addr, wr_data});
    if (protocol_err) perr_cnt++;
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Display positions as a linear index 0..79, mapped onto DDRAM addresses
  function automatic int lin_of(input logic [6:0] ac);
    if (m_n && ac >= 7'h40) return int'(ac) - 'h40 + 40;
    return int'(ac);
  endfunction

  function automatic logic [6:0] ac_of(input int lin);
    if (m_n && lin >= 40) return 7'(lin - 40 + 'h40);
    return 7'(lin);
  endfunction

  function automatic logic [6:0] ac_move(input logic up);
    return ac_of((lin_of(m_ac) + (up ? 1 : 79)) % 80);
  endfunction

  function automatic logic [5:0] sh_move(input logic up);
    return 6'((int'(m_shift) + (up ? 1 : 39)) % 40);
  endfunction

  task automatic m_reset();
    m_ac = 7'h00; m_shift = 6'd0; m_id = 1'b1; m_s = 1'b0; m_n = 1'b0;
    m_four = 1'b0; m_d = 1'b0; m_c = 1'b0; m_b = 1'b0; m_cg = 1'b0;
  endtask

  task automatic m_apply(input logic rs, input logic [7:0] b);
    int msb;
    msb = -1;
    if (rs) begin
      if (!m_cg) begin
        m_ram[m_ac] = b;
        exp_q.push_back({m_ac, b});
        m_ac = ac_move(m_id);
        if (m_s) m_shift = sh_move(m_id);
      end
    end else begin
      for (int i = 0; i < 8; i++) if (b[i]) msb = i;
      case (msb)
        0: begin
          for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
          m_ac = 7'h00; m_shift = 6'd0; m_id = 1'b1;
        end
        1: begin m_ac = 7'h00; m_shift = 6'd0; end
        2: begin m_id = b[1]; m_s = b[0]; end
        3: begin m_d = b[2]; m_c = b[1]; m_b = b[0]; end
        4: if (b[3]) m_shift = sh_move(!b[2]); else m_ac = ac_move(b[2]);
        5: begin m_four = !b[4]; m_n = b[3]; end
        6: m_cg = 1'b1;
        7: begin m_ac = b[6:0]; m_cg = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // One EN strobe; returns the driven read nibble and DB output-enable
  // observed while EN is high and after it has fallen.
  task automatic nib(input logic rs, input logic rw, input logic [3:0] d,
                     output logic [3:0] q, output logic oe_hi, output logic oe_lo);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_db_i = d;
    @(negedge clk);
    lcd_en = 1'b1;
    repeat (5) @(negedge clk);
    q = lcd_db_o;
    oe_hi = lcd_db_oe;
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    oe_lo = lcd_db_oe;
  endtask

  task automatic send(input logic rs, input logic [7:0] b);
    logic [3:0] q;
    logic oh, ol;
    nib(rs, 1'b0, b[7:4], q, oh, ol);
    if (m_four) nib(rs, 1'b0, b[3:0], q, oh, ol);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < CLEAR_CYCLES + 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_op(input logic rs, input logic [7:0] b);
    send(rs, b);
    m_apply(rs, b);
    wait_idle();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ac"}, addr_o, m_ac);
    chk({tag, ".shift"}, shift_o, m_shift);
    chk({tag, ".flags"}, {display_on, cursor_on, blink_on, four_bit, two_line},
        {m_d, m_c, m_b, m_four, m_n});
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, ".nwr"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic read_ram(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic chk_ram(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 128; i++) begin
      read_ram(7'(i), d);
      chk($sformatf("%s.ram%0d", tag, i), d, m_ram[i]);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".bus"}, {lcd_db_o, lcd_db_oe, wr_valid, wr_addr, wr_data}, 0);
    chk({tag, ".pos"}, {addr_o, shift_o}, 0);
    chk({tag, ".flags"}, {display_on, cursor_on, blink_on, four_bit, two_line,
                          busy, protocol_err}, 0);
  endtask

  initial begin
    logic [3:0] q1, q2;
    logic       oh1, ol1, oh2, ol2;
    logic [7:0] d;
    int         op;
    logic [7:0] r;

    // Reset
    reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Driver init sequence
    do_op(0, 8'h30);
    do_op(0, 8'h30);
    do_op(0, 8'h30);
    do_op(0, 8'h20);
    chk("init.four_bit_after_0x2", four_bit, 1);
    do_op(0, 8'h28);
    do_op(0, 8'h08);
    do_op(0, 8'h01);
    do_op(0, 8'h06);
    do_op(0, 8'h0C);
    do_op(0, 8'h02);
    chk("init.summary", {four_bit, two_line, display_on, cursor_on, addr_o},
        {1'b1, 1'b1, 1'b1, 1'b0, 7'h00});
    chk_state("init");
    chk("init.perr", perr_cnt, 0);

    // Data writes
    do_op(1, 8'h41);
    do_op(1, 8'h42);
    chk("data.ac", addr_o, 7'h02);
    cmp_writes("data");
    read_ram(7'h00, d);
    chk("data.ram0", d, 8'h41);
    read_ram(7'h01, d);
    chk("data.ram1", d, 8'h42);

    // Address counter wrap points in two-line mode
    do_op(0, 8'hA7);
    do_op(1, 8'h30);
    chk("wrap.27", addr_o, 7'h40);
    do_op(0, 8'hE7);
    do_op(1, 8'h31);
    chk("wrap.67", addr_o, 7'h00);
    do_op(0, 8'h04);
    do_op(0, 8'h80);
    do_op(1, 8'h32);
    chk("wrap.00dec", addr_o, 7'h67);
    do_op(0, 8'h06);
    cmp_writes("wrap");

    // Clear with a write arriving while busy
    send(0, 8'h01);
    m_apply(0, 8'h01);
    send(1, 8'h55);
    exp_perr++;
    wait_idle();
    @(negedge clk);
    chk("clear.busy_len", last_busy_len, CLEAR_CYCLES);
    chk("clear.perr", perr_cnt, exp_perr);
    cmp_writes("clear");
    chk_ram("clear");
    chk_state("clear");

    // Display shift wraps modulo 40
    for (int i = 0; i < 41; i++) do_op(0, 8'h18);
    chk("shift.41", shift_o, 6'd1);
    chk_state("shift");

    // Busy-flag read straight after a set-address
    send(0, 8'h92);
    m_apply(0, 8'h92);
    nib(0, 1, 4'h0, q1, oh1, ol1);
    nib(0, 1, 4'h0, q2, oh2, ol2);
    chk("bfread.hi", q1, 4'h9);
    chk("bfread.lo", q2, 4'h2);
    chk("bfread.oe", {oh1, ol1, oh2, ol2}, 4'b1010);
    wait_idle();

    // Data read returns zero and leaves AC alone
    nib(1, 1, 4'h0, q1, oh1, ol1);
    nib(1, 1, 4'h0, q2, oh2, ol2);
    chk("rsread.data", {q1, q2}, 8'h00);
    chk_state("rsread");

    // Mismatched RS across a nibble pair
    nib(0, 0, 4'h0, q1, oh1, ol1);
    nib(1, 0, 4'h1, q2, oh2, ol2);
    exp_perr++;
    chk("pair.perr", perr_cnt, exp_perr);
    do_op(1, 8'h5A);
    cmp_writes("pair");
    chk_state("pair");

    // Randomized operations
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 8));
      r  = 8'($urandom);
      case (op)
        0, 1, 2: do_op(1, r);
        3: do_op(0, {1'b1, ac_of(int'($urandom_range(0, 79)))});
        4: do_op(0, {6'b000001, r[1:0]});
        5: do_op(0, {4'b0001, r[3:2], 2'b00});
        6: do_op(0, {5'b00001, r[2:0]});
        7: begin
          do_op(0, {2'b01, r[5:0]});
          do_op(1, r);
          do_op(0, {1'b1, ac_of(int'($urandom_range(0, 79)))});
        end
        default: begin
          do_op(0, {4'b0010, r[3], 3'b000});
          do_op(0, {1'b1, ac_of(int'($urandom_range(0, 79)))});
        end
      endcase
      chk_state($sformatf("rand%0d", it));
    end
    cmp_writes("rand");
    chk("rand.perr", perr_cnt, exp_perr);

    // Reset in the middle of a nibble pair
    do_op(0, 8'h80);
    nib(0, 0, 4'h4, q1, oh1, ol1);
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("midpair");
    do_op(0, 8'h20);
    chk("midpair.four_bit", four_bit, 1);
    chk_state("midpair");
    cmp_writes("midpair");
    chk_ram("midpair");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc1602_bus_responder.md
# sc1602_bus_responder

Responder-side model of the SC1602 (HD44780-compatible) parallel bus. Samples EN/RS/RW/DB from the LCD pins in 4-bit or 8-bit interface mode, decodes instructions and data writes, and maintains DDRAM, the address counter and the display-state flags. It sits where the physical SC1602 would: as a bench model for the LCD driver, or on-FPGA to mirror LCD contents to another display. Its outputs include a DDRAM read port and a write-event strobe.

## Interface
- BUSY_CYCLES, 40: busy time after any instruction or data write except clear/home.
- CLEAR_CYCLES, 1600: busy time after clear display and return home; must be ≥130.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- lcd_en  in  1  LCD EN pin, asynchronous to clk.
- lcd_rs  in  1  LCD RS pin.
- lcd_rw  in  1  LCD RW pin.
- lcd_db_i  in  4  DB7..DB4 from the bus.
- lcd_db_o  out  4  DB7..DB4 driven on reads.
- lcd_db_oe  out  1  read-drive enable.
- rd_addr  in  7  DDRAM read address for the renderer.
- rd_data  out  8  DDRAM contents; 1-cycle latency.
- wr_valid  out  1  1-cycle pulse on each DDRAM data write.
- wr_addr  out  7  Address of the pulsed write.
- wr_data  out  8  Data of the pulsed write.
- addr_o  out  7  Address counter (AC).
- shift_o  out  6  Display shift offset, 0..39.
- display_on, cursor_on, blink_on  out  1 each  D/C/B flags.
- four_bit, two_line  out  1 each  DL=0 and N flags.
- busy  out  1  Busy flag (BF).
- protocol_err  out  1  1-cycle pulse on a rejected access.

## Operation
- Pin capture:
  - lcd_en, lcd_rs, lcd_rw and lcd_db_i each pass through a 2-flop synchronizer, then one more register stage.
  - An access completes on the synchronized falling edge of EN (stage2=0, stage3=1).
  - The access uses RS, RW and DB from stage3, i.e. the values held while EN was high.
- Interface mode:
  - After reset the block is in 8-bit mode. Each access is one byte, {DB7..DB4, 4'h0}.
  - A function set with DL=0 selects 4-bit mode and clears the nibble phase.
  - In 4-bit mode, accesses pair up: high nibble first, then low nibble.
  - If RS or RW differs between the two nibbles, the pair is discarded, protocol_err pulses and the phase returns to high.
- Instruction decode (RS=0, RW=0), matched on the highest set bit:
  - 0x01 clear: fill all 128 DDRAM entries with 0x20, one per cycle; AC=0; shift=0; I/D=1.
  - 0x02/03 home: AC=0, shift=0.
  - 0x04–07 entry mode: store I/D and S.
  - 0x08–0F display control: store D, C, B.
  - 0x10–1F shift:
    - S/C=0 moves AC by ±1 using the wrap rule.
    - S/C=1 changes shift_o: R/L=0 adds 1, R/L=1 subtracts 1, modulo 40.
  - 0x20–3F function set: store DL and N.
  - 0x40–7F set CGRAM address: subsequent data writes are discarded; there is no CGRAM.
  - 0x80–FF set DDRAM address: AC=byte[6:0]; leaves CGRAM-select.
- Data write (RS=1, RW=0):
  - DDRAM[AC]=byte; wr_valid pulses with the same address and data.
  - AC then steps by +1 (I/D=1) or −1 (I/D=0).
  - If S=1, shift_o also steps: +1 when I/D=1, −1 when I/D=0.
- AC wrap rule:
  - N=1: AC 0x27+1→0x40, 0x67+1→0x00, 0x40−1→0x27, 0x00−1→0x67.
  - N=0: range 0x00..0x4F, wrapping at both ends.
- Read (RW=1):
  - RS=0 returns {BF, AC}. In 4-bit mode the high nibble is {BF, AC[6:4]} and the low nibble is AC[3:0]. In 8-bit mode only {BF, AC[6:4]} is returned.
  - lcd_db_oe follows synchronized EN high with RW=1; lcd_db_o is held from the rising edge.
  - RS=1 reads return 0 and do not advance AC.
  - Reads are allowed while busy and never set busy.
- Busy:
  - Each executed write loads the counter with BUSY_CYCLES, or CLEAR_CYCLES for clear/home.
  - BF=1 while the counter is nonzero.
  - A write access completing while BF=1 is dropped and protocol_err pulses. In 4-bit mode this applies per completed pair.
- Reset:
  - Returns every register to its reset value, mid-pair and mid-clear included.
  - DDRAM is not cleared by reset.

## Timing
- Reset values:
  - lcd_db_o=0, lcd_db_oe=0, wr_valid=0, wr_addr=0, wr_data=0, addr_o=0, shift_o=0.
  - display_on=0, cursor_on=0, blink_on=0, four_bit=0, two_line=0, busy=0, protocol_err=0.
  - I/D=1, S=0, nibble phase high.
- An access's effect appears on the registered outputs at the 4th rising edge of clk after lcd_en falls at the pin. Hold margin is ±1 cycle.
- Bus timing: EN high ≥3 clk and EN low ≥3 clk; DB/RS/RW stable from EN rise to 2 clk after EN fall.
- Clear fill: 128 cycles starting the cycle after decode; BF stays set for the full CLEAR_CYCLES.
- rd_data is registered: rd_addr sampled at edge k gives data at edge k+1. A same-cycle write is visible on the following read.

## Test plan
- Driver init: 8-bit 0x3 ×3, 0x2, then 4-bit 0x28, 0x08, 0x01, 0x06, 0x0C, 0x02, each waited out. Expect four_bit=1, two_line=1, display_on=1, cursor_on=0, addr_o=0, no protocol_err.
- Data writes: after init, write 0x41 then 0x42. Expect wr_valid ×2 and DDRAM[0]=0x41, DDRAM[1]=0x42, addr_o=0x02.
- Wrap: set address 0xA7, write 0x30 → addr_o=0x40; set 0xE7, write → addr_o=0x00. Entry mode 0x04, set 0x80, write → addr_o=0x67.
- Clear and busy: fill entries, send 0x01 and immediately write 0x55. Expect protocol_err, write dropped, all 128 entries read 0x20, busy high for CLEAR_CYCLES.
- Shift and busy read: 0x18 ×41 → shift_o=1. Busy read immediately after 0x80|0x12: first nibble 0x9, second 0x2, lcd_db_oe high only while EN is high.
- Reset mid-pair: send only the high nibble 0x4, then pulse reset. Expect four_bit=0 and all outputs at their reset values; the next 8-bit access 0x2 executes as a function set.
